// File: rtl/bp_pkg.sv
// Shared constants, record type and counter helper for the branch predictor.
package bp_pkg;

   localparam int unsigned BHT_BITS = 6;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   typedef struct packed {
      logic                valid;
      logic                pred_taken;
      logic [BHT_BITS-1:0] idx;
   } bp_rec_t;

   // Two-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      if (taken) res = (cnt == ST)  ? ST  : 2'(cnt + 2'd1);
      else       res = (cnt == SNT) ? SNT : 2'(cnt - 2'd1);
      return res;
   endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table: 2-bit counters, one combinational read port and one
// synchronous saturating-update port; synchronous active-low reset.
module bp_bht
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W      = BHT_BITS,
   parameter logic [1:0]  INIT_STATE = WNT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [1:0]       rd_cnt_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   localparam int unsigned ENTRIES = 1 << IDX_W;

   logic [1:0] bht_q [ENTRIES];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= INIT_STATE;
      end else if (upd_en_i) begin
         bht_q[upd_idx_i] <= sat_update(bht_q[upd_idx_i], upd_taken_i);
      end
   end

   // Read returns the pre-update value when read and update hit the same entry.
   assign rd_cnt_o = bht_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// PC-indexed 2-bit BHT predictor for beq with EX-stage mispredict flush.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter logic [1:0]  INIT_STATE = WNT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] if_ins,
   input  logic [31:0] if_pc,
   input  logic        ex_branch,
   input  logic        ex_zero,
   output logic        predict1,
   output logic        flush,
   output logic        ex_pred_taken
`ifdef BP_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);

   bp_rec_t             rec_q [DEPTH];
   bp_rec_t             rec_d [DEPTH];
   bp_rec_t             ex_rec;
   logic [BHT_BITS-1:0] if_idx;
   logic [1:0]          rd_cnt;
   logic                is_beq;
   logic                actual;
   logic                upd_en;
   logic                unused_bits;

   assign if_idx      = if_pc[BHT_BITS+1:2];
   assign ex_rec      = rec_q[DEPTH-1];
   assign unused_bits = ^{if_pc[31:BHT_BITS+2], if_pc[1:0], if_ins[25:0]};

   bp_bht #(
      .IDX_W      (BHT_BITS),
      .INIT_STATE (INIT_STATE)
   ) u_bht (
      .clk_i       (clk),
      .rst_ni      (reset),
      .rd_idx_i    (if_idx),
      .rd_cnt_o    (rd_cnt),
      .upd_en_i    (upd_en),
      .upd_idx_i   (ex_rec.idx),
      .upd_taken_i (actual)
   );

   // Fetch lookup and EX resolution.
   always_comb begin
      is_beq        = (if_ins[31:26] == OP_BEQ);
      actual        = ex_zero & ex_branch;
      flush         = ex_rec.valid & ex_branch & (actual != ex_rec.pred_taken) & ~stall;
      predict1      = is_beq & rd_cnt[1] & ~flush;
      ex_pred_taken = ex_rec.valid & ex_rec.pred_taken;
      upd_en        = ex_rec.valid & ex_branch & ~stall;
   end

   // Record shift; a flush invalidates everything younger than the EX record.
   always_comb begin
      for (int unsigned k = 0; k < DEPTH; k++) rec_d[k] = rec_q[k];
      if (!stall) begin
         rec_d[0] = '{valid: is_beq, pred_taken: predict1, idx: if_idx};
         for (int unsigned k = 1; k < DEPTH; k++) rec_d[k] = rec_q[k-1];
         if (flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) rec_d[k].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) rec_q[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) rec_q[k] <= rec_d[k];
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] stat_br_q;
   logic [31:0] stat_mis_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         if (upd_en) stat_br_q  <= 32'(stat_br_q + 32'd1);
         if (flush)  stat_mis_q <= 32'(stat_mis_q + 32'd1);
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mis_q;
`endif

endmodule
